// File: rtl/cache_pkg.sv
// Shared definitions for the burst-refill cache controller: FSM state codes,
// the OKAY response code and the refill index width helper.
package cache_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD_ADDR = 3'd1;
  localparam logic [2:0] ST_RD_DATA = 3'd2;
  localparam logic [2:0] ST_WR_REQ  = 3'd3;
  localparam logic [2:0] ST_WR_RESP = 3'd4;

  localparam int RESP_OKAY = 0;

  // Keeps the index at least one bit wide even for degenerate line sizes.
  function automatic int idxWidth(input int lineWords);
    return (lineWords > 1) ? $clog2(lineWords) : 1;
  endfunction

endpackage

// File: rtl/cache_ctrl_burst_if.sv
// Processor, RAM-control and bus handshake bundle for cache_ctrl_burst.
// master = the cache controller, slave = its environment.
interface cache_ctrl_burst_if #(
  parameter int LINE_WORDS = 4,
  parameter int BE_W       = 4,
  parameter int RESP_W     = 32
);
  import cache_pkg::*;

  localparam int IDX_W = idxWidth(LINE_WORDS);

  logic [BE_W-1:0]   p_w_en;
  logic              p_r_en;
  logic              hit;
  logic              readAddr_ready;
  logic              readData_valid;
  logic              writeAddr_ready;
  logic              writeData_ready;
  logic              writeResp_valid;
  logic [RESP_W-1:0] writeResp_msg;

  logic              readAddr_valid;
  logic              readData_ready;
  logic              writeAddr_valid;
  logic              writeData_valid;
  logic              writeResp_ready;
  logic              p_ready;
  logic              p_err;
  logic              w_tagram;
  logic              w_validram;
  logic              w_dataram;
  logic [BE_W-1:0]   dataram_be;
  logic              dataram_sel;
  logic              validin;
  logic [IDX_W-1:0]  refill_idx;

  modport master (
    input  p_w_en, p_r_en, hit, readAddr_ready, readData_valid,
           writeAddr_ready, writeData_ready, writeResp_valid, writeResp_msg,
    output readAddr_valid, readData_ready, writeAddr_valid, writeData_valid,
           writeResp_ready, p_ready, p_err, w_tagram, w_validram, w_dataram,
           dataram_be, dataram_sel, validin, refill_idx
  );

  modport slave (
    output p_w_en, p_r_en, hit, readAddr_ready, readData_valid,
           writeAddr_ready, writeData_ready, writeResp_valid, writeResp_msg,
    input  readAddr_valid, readData_ready, writeAddr_valid, writeData_valid,
           writeResp_ready, p_ready, p_err, w_tagram, w_validram, w_dataram,
           dataram_be, dataram_sel, validin, refill_idx
  );

endinterface

// File: rtl/cache_ctrl_burst_beat_cnt.sv
// Refill beat counter (cache_beat_cnt): counts words within a line and flags
// the final word; shared with the line-writeback path.
module cache_beat_cnt
  import cache_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  localparam int IDX_W = idxWidth(LINE_WORDS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [IDX_W-1:0] o_cnt,
  output logic             o_last
);

  logic [IDX_W-1:0] r_cnt;

  // LINE_WORDS is a power of two, so the increment wraps to 0 after the last word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_last = (r_cnt == IDX_W'(LINE_WORDS - 1));

endmodule

// File: rtl/cache_ctrl_burst.sv
// Control FSM for a direct-mapped write-through cache with burst line refill.
// Define CACHE_WRITE_ALLOCATE_EN to refill the line on a write miss first.
module cache_ctrl_burst
  import cache_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int BE_W       = 4,
  parameter int RESP_W     = 32
) (
  input logic                clk,
  input logic                rst_n,
  cache_ctrl_burst_if.master bus
);

  localparam int IDX_W = idxWidth(LINE_WORDS);

  logic [2:0]       r_state;
  logic [2:0]       w_nextState;
  logic             r_awDone;
  logic             r_wDone;
  logic             r_hitQ;
  logic [BE_W-1:0]  r_beQ;

  logic             w_wrReq;
  logic             w_latchWr;
  logic             w_cntClr;
  logic             w_cntInc;
  logic             w_cntLast;
  logic [IDX_W-1:0] w_cnt;
  logic             w_awNext;
  logic             w_wNext;
  logic             w_respOk;

  assign w_wrReq  = |bus.p_w_en;
  assign w_awNext = r_awDone | bus.writeAddr_ready;
  assign w_wNext  = r_wDone | bus.writeData_ready;
  assign w_respOk = (bus.writeResp_msg == RESP_W'(RESP_OKAY));

  cache_beat_cnt #(.LINE_WORDS(LINE_WORDS)) u_beatCnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_cntClr),
    .i_inc  (w_cntInc),
    .o_cnt  (w_cnt),
    .o_last (w_cntLast)
  );

  always_comb begin
    w_nextState         = r_state;
    w_latchWr           = 1'b0;
    w_cntClr            = 1'b0;
    w_cntInc            = 1'b0;
    bus.readAddr_valid  = 1'b0;
    bus.readData_ready  = 1'b0;
    bus.writeAddr_valid = 1'b0;
    bus.writeData_valid = 1'b0;
    bus.writeResp_ready = 1'b0;
    bus.p_ready         = 1'b0;
    bus.p_err           = 1'b0;
    bus.w_tagram        = 1'b0;
    bus.w_validram      = 1'b0;
    bus.w_dataram       = 1'b0;
    bus.dataram_be      = '0;
    bus.dataram_sel     = 1'b0;
    bus.validin         = 1'b0;
    bus.refill_idx      = '0;

    case (r_state)
      ST_IDLE: begin
        // A write outranks a simultaneous read; the read is simply not serviced.
        if (w_wrReq) begin
`ifdef CACHE_WRITE_ALLOCATE_EN
          if (!bus.hit) begin
            w_cntClr    = 1'b1;
            w_nextState = ST_RD_ADDR;
          end else begin
            w_latchWr   = 1'b1;
            w_nextState = ST_WR_REQ;
          end
`else
          w_latchWr   = 1'b1;
          w_nextState = ST_WR_REQ;
`endif
        end else if (bus.p_r_en) begin
          if (bus.hit) begin
            bus.p_ready = rst_n;
          end else begin
            w_cntClr    = 1'b1;
            w_nextState = ST_RD_ADDR;
          end
        end
      end

      ST_RD_ADDR: begin
        bus.readAddr_valid = 1'b1;
        if (bus.readAddr_ready) w_nextState = ST_RD_DATA;
      end

      ST_RD_DATA: begin
        bus.readData_ready = 1'b1;
        bus.refill_idx     = w_cnt;
        bus.dataram_be     = '1;
        if (bus.readData_valid) begin
          bus.w_dataram = 1'b1;
          w_cntInc      = 1'b1;
          if (w_cntLast) begin
            bus.w_tagram   = 1'b1;
            bus.w_validram = 1'b1;
            bus.validin    = 1'b1;
            w_nextState    = ST_IDLE;
          end
        end
      end

      ST_WR_REQ: begin
        bus.writeAddr_valid = !r_awDone;
        bus.writeData_valid = !r_wDone;
        if (w_awNext && w_wNext) w_nextState = ST_WR_RESP;
      end

      ST_WR_RESP: begin
        bus.writeResp_ready = 1'b1;
        if (bus.writeResp_valid) begin
          bus.p_ready = 1'b1;
          bus.p_err   = !w_respOk;
          w_nextState = ST_IDLE;
          if (r_hitQ && w_respOk) begin
            bus.w_dataram   = 1'b1;
            bus.dataram_sel = 1'b1;
            bus.dataram_be  = r_beQ;
          end
        end
      end

      default: w_nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Address and data channels complete independently; flags clear once both are in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_awDone <= 1'b0;
      r_wDone  <= 1'b0;
      r_hitQ   <= 1'b0;
      r_beQ    <= '0;
    end else begin
      if (w_latchWr) begin
        r_beQ  <= bus.p_w_en;
        r_hitQ <= bus.hit;
      end
      if (r_state == ST_WR_REQ) begin
        if (w_awNext && w_wNext) begin
          r_awDone <= 1'b0;
          r_wDone  <= 1'b0;
        end else begin
          r_awDone <= w_awNext;
          r_wDone  <= w_wNext;
        end
      end
    end
  end

endmodule

// File: tb/tb_cache_ctrl_burst.sv
// Randomized self-checking bench for cache_ctrl_burst against a transaction-level
// model; honours CACHE_WRITE_ALLOCATE_EN the same way as the design.
module tb_cache_ctrl_burst;

  localparam int LW     = 4;
  localparam int BE_W   = 4;
  localparam int RESP_W = 32;
  localparam int IDX_W  = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  cache_ctrl_burst_if #(.LINE_WORDS(LW), .BE_W(BE_W), .RESP_W(RESP_W)) bus ();

  cache_ctrl_burst #(.LINE_WORDS(LW), .BE_W(BE_W), .RESP_W(RESP_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic             pReady;
    logic             pErr;
    logic             raV;
    logic             rdR;
    logic             awV;
    logic             wdV;
    logic             brR;
    logic             wTag;
    logic             wVal;
    logic             wData;
    logic [BE_W-1:0]  be;
    logic             sel;
    logic             vin;
    logic [IDX_W-1:0] idx;
  } outs_t;

  int vectors     = 0;
  int miscompares = 0;
  bit lineValid[8];
  int addr;

  function automatic outs_t observe();
    outs_t o;
    o.pReady = bus.p_ready;
    o.pErr   = bus.p_err;
    o.raV    = bus.readAddr_valid;
    o.rdR    = bus.readData_ready;
    o.awV    = bus.writeAddr_valid;
    o.wdV    = bus.writeData_valid;
    o.brR    = bus.writeResp_ready;
    o.wTag   = bus.w_tagram;
    o.wVal   = bus.w_validram;
    o.wData  = bus.w_dataram;
    o.be     = bus.dataram_be;
    o.sel    = bus.dataram_sel;
    o.vin    = bus.validin;
    o.idx    = bus.refill_idx;
    return o;
  endfunction

  task automatic checkOutput(input string tag, input outs_t got, input outs_t want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic applyStimulus(input string tag, input outs_t want);
    @(negedge clk);
    checkOutput(tag, observe(), want);
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    bus.p_w_en          = '0;
    bus.p_r_en          = 1'b0;
    bus.hit             = 1'b0;
    bus.readAddr_ready  = 1'b0;
    bus.readData_valid  = 1'b0;
    bus.writeAddr_ready = 1'b0;
    bus.writeData_ready = 1'b0;
    bus.writeResp_valid = 1'b0;
    bus.writeResp_msg   = '0;
  endtask

  // Full-line refill of lineValid[addr]; the request itself is held by the caller.
  task automatic refill(input int addrDelay, input logic [LW-1:0] gapMask);
    outs_t e;
    bus.hit = 1'b0;
    e = '0;
    applyStimulus("idleMiss", e);
    for (int i = 0; i <= addrDelay; i++) begin
      bus.readAddr_ready = (i == addrDelay);
      e = '0; e.raV = 1'b1;
      applyStimulus("rdAddr", e);
    end
    bus.readAddr_ready = 1'b0;
    for (int k = 0; k < LW; k++) begin
      e = '0; e.rdR = 1'b1; e.be = '1; e.idx = IDX_W'(k);
      if (gapMask[k]) begin
        bus.readData_valid = 1'b0;
        applyStimulus("rdGap", e);
      end
      bus.readData_valid = 1'b1;
      e.wData = 1'b1;
      e.wTag  = (k == LW - 1);
      e.wVal  = (k == LW - 1);
      e.vin   = (k == LW - 1);
      applyStimulus("rdBeat", e);
    end
    bus.readData_valid = 1'b0;
    lineValid[addr] = 1'b1;
    bus.hit = 1'b1;
  endtask

  task automatic readReq(input int addrDelay, input logic [LW-1:0] gapMask);
    outs_t e;
    bus.p_r_en = 1'b1;
    bus.hit    = lineValid[addr];
    if (!lineValid[addr]) refill(addrDelay, gapMask);
    e = '0; e.pReady = 1'b1;
    applyStimulus(lineValid[addr] ? "rdDone" : "rdHit", e);
    clearInputs();
  endtask

  task automatic writeReq(input logic [BE_W-1:0] be, input int ta, input int tw,
                          input int dr, input logic [RESP_W-1:0] msg, input bit alsoRead);
    outs_t e;
    bit    hitQ;
    bit    ok;
    int    n;
    bus.p_w_en = be;
    bus.p_r_en = alsoRead;
    bus.hit    = lineValid[addr];
`ifdef CACHE_WRITE_ALLOCATE_EN
    if (!lineValid[addr]) refill(int'($urandom_range(0, 2)), LW'($urandom));
`endif
    hitQ = lineValid[addr];
    e = '0;
    applyStimulus("wrIdle", e);
    n = (ta > tw) ? ta : tw;
    for (int i = 0; i <= n; i++) begin
      bus.writeAddr_ready = (i == ta);
      bus.writeData_ready = (i == tw);
      e = '0; e.awV = (i <= ta); e.wdV = (i <= tw);
      applyStimulus("wrReq", e);
    end
    bus.writeAddr_ready = 1'b0;
    bus.writeData_ready = 1'b0;
    for (int d = 0; d < dr; d++) begin
      e = '0; e.brR = 1'b1;
      applyStimulus("wrWait", e);
    end
    ok = (msg == '0);
    bus.writeResp_valid = 1'b1;
    bus.writeResp_msg   = msg;
    e = '0; e.brR = 1'b1; e.pReady = 1'b1; e.pErr = !ok;
    if (hitQ && ok) begin
      e.wData = 1'b1; e.sel = 1'b1; e.be = be;
    end
    applyStimulus("wrResp", e);
    clearInputs();
  endtask

  // Reset lands mid-refill: outputs drop at once and the line stays invalid.
  task automatic resetMidBurst();
    outs_t e;
    bus.p_r_en = 1'b1;
    bus.hit    = 1'b0;
    e = '0;
    applyStimulus("rstIdle", e);
    bus.readAddr_ready = 1'b1;
    e = '0; e.raV = 1'b1;
    applyStimulus("rstAddr", e);
    bus.readAddr_ready = 1'b0;
    bus.readData_valid = 1'b1;
    e = '0; e.rdR = 1'b1; e.be = '1; e.wData = 1'b1;
    applyStimulus("rstBeat0", e);
    rst_n = 1'b0;
    #1;
    checkOutput("rstAsync", observe(), '0);
    clearInputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    clearInputs();
    bus.p_r_en         = 1'b1;
    bus.hit            = 1'b1;
    bus.readData_valid = 1'b1;
    #12;
    checkOutput("reset", observe(), '0);
    clearInputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    addr = 0;
    readReq(2, 4'b0100);
    readReq(0, '0);
    writeReq(4'b0011, 1, 0, 1, '0, 1'b0);
    writeReq(4'b1100, 0, 0, 0, 32'h2, 1'b0);
    writeReq(4'b0101, 2, 2, 0, '0, 1'b1);

    addr = 5;
    writeReq(4'b1111, 0, 1, 1, '0, 1'b0);

    addr = 3;
    resetMidBurst();
    readReq(1, '0);

    for (int t = 0; t < 40; t++) begin
      addr = int'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 0) begin
        readReq(int'($urandom_range(0, 3)), LW'($urandom));
      end else begin
        writeReq(BE_W'($urandom_range(1, 15)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                 ($urandom_range(0, 3) == 0) ? RESP_W'($urandom_range(1, 255)) : '0,
                 1'($urandom_range(0, 1)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cache_ctrl_burst.md
Name: cache_ctrl_burst

Overview:
- Control FSM for a direct-mapped, write-through cache with multi-word lines.
- Refills a whole line of LINE_WORDS words over a bus read burst.
- Handles the bus write-address and write-data channels independently.
- Reports write-response errors to the processor.
- Sits between the processor request port, the tag/valid/data RAMs and the system bus; the datapath (tag compare, muxes, RAMs) is external.

Parameters:
- LINE_WORDS, 4, words per cache line; power of two, at least 2.
- BE_W, 4, processor byte-enable width.
- RESP_W, 32, width of writeResp_msg; value 0 = OKAY, any other value = error.
- IDX_W (localparam), $clog2(LINE_WORDS), width of the refill word index.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- p_w_en  in  BE_W  processor write byte enables; any bit set = write request.
- p_r_en  in  1  processor read request.
- hit  in  1  tag match and valid for the current processor address.
- readAddr_ready, readData_valid, writeAddr_ready, writeData_ready, writeResp_valid  in  1  bus handshakes.
- writeResp_msg  in  RESP_W  write response code.
- readAddr_valid, readData_ready, writeAddr_valid, writeData_valid, writeResp_ready  out  1  bus handshakes.
- p_ready  out  1  request complete (one-cycle pulse).
- p_err  out  1  qualifies p_ready: write got an error response.
- w_tagram, w_validram, w_dataram  out  1  RAM write enables.
- dataram_be  out  BE_W  data RAM byte enables.
- dataram_sel  out  1  data RAM source: 0 = bus read data, 1 = processor write data.
- validin  out  1  value written to the valid RAM.
- refill_idx  out  IDX_W  word-in-line index for refill writes.

Behaviour:
- Reset:
  - rst_n low forces IDLE immediately (asynchronous).
  - Beat counter, aw_done, w_done, hit_q and be_q clear.
  - Every output is 0.
  - Reset mid-burst or mid-write abandons the transaction; the valid RAM is not written.
- Processor protocol: the request and address are held stable until p_ready. If read and write are asserted together, the write wins and the read is not serviced.
- IDLE:
  - read & hit: p_ready=1 combinationally, stay in IDLE (0-cycle hit).
  - read & !hit: go to RD_ADDR; clear the beat counter.
  - write: latch p_w_en into be_q and hit into hit_q; go to WR_REQ.
- RD_ADDR:
  - readAddr_valid=1.
  - On readAddr_ready, go to RD_DATA.
- RD_DATA:
  - readData_ready=1, dataram_sel=0, refill_idx = beat count, dataram_be = all ones.
  - Each beat with readData_valid: w_dataram=1; the counter increments.
  - Last beat (count==LINE_WORDS-1): additionally w_tagram=1, w_validram=1, validin=1; go to IDLE, counter wraps to 0.
  - Read-miss latency: the hit is re-evaluated in IDLE the cycle after the last beat, and p_ready pulses then.
- WR_REQ:
  - writeAddr_valid = !aw_done; writeData_valid = !w_done.
  - An address handshake sets aw_done; a data handshake sets w_done. Both may occur in the same cycle or in any order.
  - When both are done (including same-cycle completion): clear the flags, go to WR_RESP.
- WR_RESP:
  - writeResp_ready=1.
  - On writeResp_valid: p_ready=1 and p_err = (writeResp_msg != 0); go to IDLE.
  - If hit_q and OKAY: also w_dataram=1, dataram_sel=1, dataram_be=be_q.
  - Errors never update the cache.
- Tag/valid RAMs are never written on a write.
- Unused encodings: go to IDLE with outputs 0.

Optional Feature:
- CACHE_WRITE_ALLOCATE_EN defined:
  - A write in IDLE with !hit first takes RD_ADDR→RD_DATA (full line refill) and returns to IDLE.
  - The held write then sees hit=1 and proceeds as a write hit; the data RAM updates on the OKAY response.
- Undefined (no-write-allocate): a write miss goes straight to WR_REQ; the cache is untouched.

Decomposition:
- Package cache_pkg: state enum (IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP), RESP_OKAY=0, IDX_W derivation function.
- Sub-module cache_beat_cnt: IDX_W-bit counter with clear/inc/last outputs. Reused later by the line-writeback block.

Test Plan:
- Read hit: p_r_en=1, hit=1 → p_ready=1 the same cycle; no bus valid asserted.
- Read miss, LINE_WORDS=4, readAddr_ready delayed 2 cycles, 4 beats with a one-cycle gap before beat 2:
  - readAddr_valid held 3 cycles.
  - w_dataram pulses with refill_idx 0,1,2,3.
  - w_tagram/w_validram/validin only on beat 3.
  - p_ready one cycle after beat 3 once hit=1.
- Write hit, p_w_en=4'b0011, writeData_ready 1 cycle before writeAddr_ready:
  - writeData_valid drops after its handshake; writeAddr_valid is held until its own.
  - OKAY response → w_dataram=1, dataram_be=0011, dataram_sel=1, p_ready=1, p_err=0.
- Write hit, writeResp_msg=32'h2 → p_ready=1, p_err=1, w_dataram=0.
- Write miss:
  - Without CACHE_WRITE_ALLOCATE_EN: bus write only, no RAM enables.
  - With it: 4-beat refill first, then the write, then dataram update.
- Assert rst_n low during RD_DATA beat 1 → all outputs 0 immediately; the next read miss restarts at refill_idx 0.
